// File: rtl/dram_cache_pkg.sv
// Shared defaults, response codes, FSM state types and tag-word packing
// for the DRAM-cache AXI slave.
package dram_cache_pkg;

  localparam int unsigned ADDR_W_DEF   = 64;
  localparam int unsigned DATA_W_DEF   = 512;
  localparam int unsigned ID_W_DEF     = 16;
  localparam int unsigned TAG_S_DEF    = 64;
  localparam int unsigned INDEX_W_DEF  = 10;
  localparam int unsigned OFFSET_W_DEF = 6;
  localparam int unsigned RD_LAT_DEF   = 2;

  // Widest tag word the pack/unpack helpers can handle.
  localparam int unsigned TAG_MAX = 256;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_e;

  // Word layout: [tag_s-1]=valid, [tag_s-2]=dirty, then tw tag bits, zeros below.
  function automatic logic [TAG_MAX-1:0] pack_tag(input logic valid, input logic dirty,
                                                  input logic [TAG_MAX-1:0] tag,
                                                  input int unsigned tag_s, input int unsigned tw);
    logic [TAG_MAX-1:0] w;
    w = tag << (tag_s - 2 - tw);
    w[tag_s-1] = valid;
    w[tag_s-2] = dirty;
    return w;
  endfunction

  function automatic logic [TAG_MAX-1:0] unpack_tag(input logic [TAG_MAX-1:0] word,
                                                    input int unsigned tag_s, input int unsigned tw);
    logic [TAG_MAX-1:0] mask;
    mask = (TAG_MAX'(1) << tw) - TAG_MAX'(1);
    return (word >> (tag_s - 2 - tw)) & mask;
  endfunction

endpackage

// File: rtl/dcache_tag_data_ram.sv
// Tag/data storage: one write port, one combinational read port with
// write-first bypass, and per-entry valid flops cleared by reset.
module dcache_tag_data_ram #(
  parameter int unsigned TAG_S   = 64,
  parameter int unsigned DATA_W  = 512,
  parameter int unsigned INDEX_W = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               we,
  input  logic [INDEX_W-1:0] waddr,
  input  logic [TAG_S-1:0]   wtag,
  input  logic [DATA_W-1:0]  wdata,
  input  logic [INDEX_W-1:0] raddr,
  output logic [TAG_S-1:0]   rtag,
  output logic [DATA_W-1:0]  rdata
);

  localparam int unsigned DEPTH = 2 ** INDEX_W;

  logic [TAG_S-2:0]  tag_mem  [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [DEPTH-1:0]  valid_q;

  always_ff @(posedge clk) begin
    if (we) begin
      tag_mem[waddr]  <= wtag[TAG_S-2:0];
      data_mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (we) begin
      valid_q[waddr] <= wtag[TAG_S-1];
    end
  end

  always_comb begin
    if (we && (waddr == raddr)) begin
      rtag  = wtag;
      rdata = wdata;
    end else begin
      rtag  = {valid_q[raddr], tag_mem[raddr]};
      rdata = data_mem[raddr];
    end
  end

endmodule

// File: rtl/dram_cache_axi_slave_p.sv
// AXI-style slave fronting a direct-mapped DRAM-cache tag/data array;
// independent write (AW/W/B) and read (AR/R) FSMs with registered outputs.
module dram_cache_axi_slave_p
  import dram_cache_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ID_W     = ID_W_DEF,
  parameter int unsigned TAG_S    = TAG_S_DEF,
  parameter int unsigned INDEX_W  = INDEX_W_DEF,
  parameter int unsigned OFFSET_W = OFFSET_W_DEF,
  parameter int unsigned RD_LAT   = RD_LAT_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ID_W-1:0]         arid_i,
  input  logic [ADDR_W-1:0]       araddr_i,
  input  logic                    arvalid_i,
  output logic                    arready_o,
  output logic [ID_W-1:0]         rid_o,
  output logic [TAG_S+DATA_W-1:0] rdata_o,
  output logic [1:0]              rresp_o,
  output logic                    rhit_o,
  output logic                    rvalid_o,
  input  logic                    rready_i,
  input  logic [ID_W-1:0]         awid_i,
  input  logic [ADDR_W-1:0]       awaddr_i,
  input  logic                    awuser_i,
  input  logic                    awvalid_i,
  output logic                    awready_o,
  input  logic [ID_W-1:0]         wid_i,
  input  logic [DATA_W-1:0]       wdata_i,
  input  logic                    wvalid_i,
  output logic                    wready_o,
  output logic [ID_W-1:0]         bid_o,
  output logic [1:0]              bresp_o,
  output logic                    bvalid_o,
  input  logic                    bready_i
);

  localparam int unsigned TW = ADDR_W - INDEX_W - OFFSET_W;
  localparam logic [3:0]  LAT = 4'(RD_LAT);

  if ((TW + 2 > TAG_S) || (TAG_S >= TAG_MAX)) begin : g_tag_check
    $error("TAG_S cannot hold valid, dirty and the tag field");
  end

  w_state_e w_state, w_next;
  r_state_e r_state, r_next;

  logic [ID_W-1:0]    aw_id_q, ar_id_q;
  logic [INDEX_W-1:0] aw_idx_q, ar_idx_q;
  logic [TW-1:0]      aw_tag_q, ar_tag_q;
  logic               aw_dirty_q;
  logic [3:0]         rd_cnt;

  logic               aw_hs, ar_hs, we, hit;
  logic [TAG_S-1:0]   wtag, rtag;
  logic [DATA_W-1:0]  ram_rdata;
  logic [TAG_MAX-1:0] wtag_full, rtag_field;
  logic               unused_bits;

  assign aw_hs = awvalid_i & awready_o;
  assign ar_hs = arvalid_i & arready_o;
  assign we    = (w_state == W_DATA) && wvalid_i && (wid_i == aw_id_q);

  always_comb begin
    wtag_full  = pack_tag(1'b1, aw_dirty_q, TAG_MAX'(aw_tag_q), TAG_S, TW);
    wtag       = wtag_full[TAG_S-1:0];
    rtag_field = unpack_tag(TAG_MAX'(rtag), TAG_S, TW);
    hit        = rtag[TAG_S-1] && (rtag_field == TAG_MAX'(ar_tag_q));
  end

  assign unused_bits = ^{araddr_i[OFFSET_W-1:0], awaddr_i[OFFSET_W-1:0],
                         wtag_full[TAG_MAX-1:TAG_S]};

  dcache_tag_data_ram #(
    .TAG_S  (TAG_S),
    .DATA_W (DATA_W),
    .INDEX_W(INDEX_W)
  ) u_ram (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (we),
    .waddr(aw_idx_q),
    .wtag (wtag),
    .wdata(wdata_i),
    .raddr(ar_idx_q),
    .rtag (rtag),
    .rdata(ram_rdata)
  );

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (aw_hs) w_next = W_DATA;
      W_DATA:  if (wvalid_i) w_next = W_RESP;
      W_RESP:  if (bready_i) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state    <= W_IDLE;
      awready_o  <= 1'b0;
      wready_o   <= 1'b0;
      bvalid_o   <= 1'b0;
      bid_o      <= '0;
      bresp_o    <= '0;
      aw_id_q    <= '0;
      aw_idx_q   <= '0;
      aw_tag_q   <= '0;
      aw_dirty_q <= 1'b0;
    end else begin
      w_state   <= w_next;
      awready_o <= (w_next == W_IDLE);
      wready_o  <= (w_next == W_DATA);
      bvalid_o  <= (w_next == W_RESP);
      if (aw_hs) begin
        aw_id_q    <= awid_i;
        aw_idx_q   <= awaddr_i[INDEX_W+OFFSET_W-1:OFFSET_W];
        aw_tag_q   <= awaddr_i[ADDR_W-1:INDEX_W+OFFSET_W];
        aw_dirty_q <= awuser_i;
      end
      if ((w_state == W_DATA) && wvalid_i) begin
        bid_o   <= aw_id_q;
        bresp_o <= we ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  // The first R_DATA cycle samples the array (rvalid_o still low); that
  // extra cycle is what makes the handshake-to-rvalid latency RD_LAT+1.
  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_next = (RD_LAT == 0) ? R_DATA : R_WAIT;
      R_WAIT:  if (rd_cnt <= 4'd1) r_next = R_DATA;
      R_DATA:  if (rvalid_o && rready_i) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= R_IDLE;
      arready_o <= 1'b0;
      rvalid_o  <= 1'b0;
      rdata_o   <= '0;
      rid_o     <= '0;
      rresp_o   <= '0;
      rhit_o    <= 1'b0;
      rd_cnt    <= '0;
      ar_id_q   <= '0;
      ar_idx_q  <= '0;
      ar_tag_q  <= '0;
    end else begin
      r_state   <= r_next;
      arready_o <= (r_next == R_IDLE);
      if (ar_hs) begin
        ar_id_q  <= arid_i;
        ar_idx_q <= araddr_i[INDEX_W+OFFSET_W-1:OFFSET_W];
        ar_tag_q <= araddr_i[ADDR_W-1:INDEX_W+OFFSET_W];
        rd_cnt   <= LAT;
      end else if ((r_state == R_WAIT) && (rd_cnt != 4'd0)) begin
        rd_cnt <= rd_cnt - 4'd1;
      end
      if ((r_state == R_DATA) && !rvalid_o) begin
        rdata_o  <= {rtag, ram_rdata};
        rid_o    <= ar_id_q;
        rhit_o   <= hit;
        rresp_o  <= RESP_OKAY;
        rvalid_o <= 1'b1;
      end else if ((r_state == R_DATA) && rready_i) begin
        rvalid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dram_cache_axi_slave_p.sv
// Scoreboard bench for dram_cache_axi_slave_p: expected B/R responses are
// queued from a reference memory model when stimulus is issued.
module tb_dram_cache_axi_slave_p;

  localparam int unsigned RD_LAT = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [15:0]  arid_i = '0;
  logic [63:0]  araddr_i = '0;
  logic         arvalid_i = 1'b0;
  logic         arready_o;
  logic [15:0]  rid_o;
  logic [575:0] rdata_o;
  logic [1:0]   rresp_o;
  logic         rhit_o;
  logic         rvalid_o;
  logic         rready_i = 1'b0;
  logic [15:0]  awid_i = '0;
  logic [63:0]  awaddr_i = '0;
  logic         awuser_i = 1'b0;
  logic         awvalid_i = 1'b0;
  logic         awready_o;
  logic [15:0]  wid_i = '0;
  logic [511:0] wdata_i = '0;
  logic         wvalid_i = 1'b0;
  logic         wready_o;
  logic [15:0]  bid_o;
  logic [1:0]   bresp_o;
  logic         bvalid_o;
  logic         bready_i = 1'b0;

  dram_cache_axi_slave_p #(.RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .arid_i(arid_i), .araddr_i(araddr_i), .arvalid_i(arvalid_i), .arready_o(arready_o),
    .rid_o(rid_o), .rdata_o(rdata_o), .rresp_o(rresp_o), .rhit_o(rhit_o),
    .rvalid_o(rvalid_o), .rready_i(rready_i),
    .awid_i(awid_i), .awaddr_i(awaddr_i), .awuser_i(awuser_i), .awvalid_i(awvalid_i),
    .awready_o(awready_o),
    .wid_i(wid_i), .wdata_i(wdata_i), .wvalid_i(wvalid_i), .wready_o(wready_o),
    .bid_o(bid_o), .bresp_o(bresp_o), .bvalid_o(bvalid_o), .bready_i(bready_i)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [15:0]  id;
    logic         valid;
    logic         hit;
    logic [63:0]  tagw;
    logic [511:0] data;
  } rexp_t;

  typedef struct {
    logic [15:0] id;
    logic [1:0]  resp;
  } bexp_t;

  rexp_t rq[$];
  bexp_t bq[$];

  logic         m_valid [1024];
  logic [63:0]  m_tag   [1024];
  logic [511:0] m_data  [1024];

  function automatic logic [9:0] idx_of(input logic [63:0] a);
    return a[15:6];
  endfunction

  function automatic logic [63:0] tagword(input logic [63:0] a, input logic d);
    return {1'b1, d, a[63:16], 14'h0};
  endfunction

  function automatic logic [511:0] rand_line();
    logic [511:0] d;
    for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 1024; i++) m_valid[i] = 1'b0;
    rq.delete();
    bq.delete();
  endtask

  task automatic push_write(input logic [15:0] id, input logic [63:0] addr, input logic user,
                            input logic [15:0] wid, input logic [511:0] data);
    bexp_t b;
    b.id   = id;
    b.resp = (wid == id) ? 2'b00 : 2'b10;
    if (wid == id) begin
      m_valid[idx_of(addr)] = 1'b1;
      m_tag[idx_of(addr)]   = tagword(addr, user);
      m_data[idx_of(addr)]  = data;
    end
    bq.push_back(b);
  endtask

  task automatic push_read(input logic [15:0] id, input logic [63:0] addr);
    rexp_t e;
    logic [9:0] i;
    i       = idx_of(addr);
    e.id    = id;
    e.valid = m_valid[i];
    e.hit   = m_valid[i] && (m_tag[i][61:14] == addr[63:16]);
    e.tagw  = m_tag[i];
    e.data  = m_data[i];
    rq.push_back(e);
  endtask

  task automatic send_aw(input logic [15:0] id, input logic [63:0] addr, input logic user);
    int n;
    @(negedge clk);
    awid_i = id; awaddr_i = addr; awuser_i = user; awvalid_i = 1'b1;
    n = 0;
    while (awready_o !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (awready_o !== 1'b1) begin
      total++;
      $display("FAIL aw_timeout: awready=%b after %0d cycles, want 1", awready_o, n);
    end
    @(negedge clk);
    awvalid_i = 1'b0;
  endtask

  task automatic send_w(input logic [15:0] wid, input logic [511:0] data);
    int n;
    @(negedge clk);
    wid_i = wid; wdata_i = data; wvalid_i = 1'b1;
    n = 0;
    while (wready_o !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (wready_o !== 1'b1) begin
      total++;
      $display("FAIL w_timeout: wready=%b after %0d cycles, want 1", wready_o, n);
    end
    @(negedge clk);
    wvalid_i = 1'b0;
  endtask

  task automatic send_ar(input logic [15:0] id, input logic [63:0] addr);
    int n;
    @(negedge clk);
    arid_i = id; araddr_i = addr; arvalid_i = 1'b1;
    n = 0;
    while (arready_o !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (arready_o !== 1'b1) begin
      total++;
      $display("FAIL ar_timeout: arready=%b after %0d cycles, want 1", arready_o, n);
    end
    @(negedge clk);
    arvalid_i = 1'b0;
  endtask

  task automatic recv_b();
    int n;
    bexp_t e;
    n = 0;
    while (bvalid_o !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    total++;
    if (bvalid_o !== 1'b1) begin
      $display("FAIL b_timeout: bvalid=%b after %0d cycles, want 1", bvalid_o, n);
      return;
    end
    if (bq.size() == 0) begin
      $display("FAIL b_queue: got unexpected response bid=%h, want none", bid_o);
      return;
    end
    e = bq.pop_front();
    if (bid_o !== e.id) $display("FAIL b_id: got %h want %h", bid_o, e.id);
    else passed++;
    total++;
    if (bresp_o !== e.resp) $display("FAIL b_resp: got %b want %b", bresp_o, e.resp);
    else passed++;
    bready_i = 1'b1;
    @(negedge clk);
    bready_i = 1'b0;
    total++;
    if (bvalid_o !== 1'b0) $display("FAIL b_drop: bvalid=%b want 0", bvalid_o);
    else passed++;
  endtask

  task automatic recv_r(input int exp_lat);
    int n;
    rexp_t e;
    n = 0;
    while (rvalid_o !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (rvalid_o !== 1'b1) begin
      total++;
      $display("FAIL r_timeout: rvalid=%b after %0d cycles, want 1", rvalid_o, n);
      return;
    end
    if (exp_lat >= 0) begin
      total++;
      if (n != exp_lat) $display("FAIL r_latency: got %0d want %0d", n, exp_lat);
      else passed++;
    end
    if (rq.size() == 0) begin
      total++;
      $display("FAIL r_queue: got unexpected response rid=%h, want none", rid_o);
      return;
    end
    e = rq.pop_front();
    total++;
    if (rid_o !== e.id) $display("FAIL r_id: got %h want %h", rid_o, e.id);
    else passed++;
    total++;
    if (rresp_o !== 2'b00) $display("FAIL r_resp: got %b want 00", rresp_o);
    else passed++;
    total++;
    if (rhit_o !== e.hit) $display("FAIL r_hit: got %b want %b", rhit_o, e.hit);
    else passed++;
    total++;
    if (rdata_o[575] !== e.valid) $display("FAIL r_valid_bit: got %b want %b", rdata_o[575], e.valid);
    else passed++;
    if (e.valid) begin
      total++;
      if (rdata_o[575:512] !== e.tagw) $display("FAIL r_tagword: got %h want %h", rdata_o[575:512], e.tagw);
      else passed++;
      total++;
      if (rdata_o[511:0] !== e.data) $display("FAIL r_data: got %h want %h", rdata_o[511:0], e.data);
      else passed++;
    end
    rready_i = 1'b1;
    @(negedge clk);
    rready_i = 1'b0;
    total++;
    if (rvalid_o !== 1'b0) $display("FAIL r_drop: rvalid=%b want 0", rvalid_o);
    else passed++;
  endtask

  task automatic write_txn(input logic [15:0] id, input logic [63:0] addr, input logic user,
                           input logic [15:0] wid, input logic [511:0] data);
    push_write(id, addr, user, wid, data);
    send_aw(id, addr, user);
    send_w(wid, data);
    recv_b();
  endtask

  task automatic read_txn(input logic [15:0] id, input logic [63:0] addr);
    push_read(id, addr);
    send_ar(id, addr);
    recv_r(int'(RD_LAT) + 1);
  endtask

  localparam logic [63:0] ADDR_A = 64'h0000_1234_0000_0040;
  localparam logic [63:0] ADDR_C = 64'h0000_00AB_CD00_01C0;
  logic [511:0] data_a = {8{64'hDEAD_BEEF_0123_4567}};

  task automatic test_reset();
    model_clear();
    #3;
    total++;
    if ({arready_o, awready_o, rvalid_o, bvalid_o, wready_o} !== 5'b0)
      $display("FAIL reset_valids: ar/aw/r/b/w=%b want 00000",
               {arready_o, awready_o, rvalid_o, bvalid_o, wready_o});
    else passed++;
    total++;
    if ({rdata_o, rid_o, bid_o, rresp_o, bresp_o, rhit_o} !== '0)
      $display("FAIL reset_data: rdata=%h rid=%h bid=%h want all 0", rdata_o, rid_o, bid_o);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if ({arready_o, awready_o} !== 2'b11)
      $display("FAIL reset_ready: arready/awready=%b want 11", {arready_o, awready_o});
    else passed++;
  endtask

  task automatic test_write_read_hit();
    write_txn(16'd5, ADDR_A, 1'b1, 16'd5, data_a);
    read_txn(16'd9, ADDR_A);
  endtask

  task automatic test_unwritten_read();
    read_txn(16'd3, 64'h0000_0000_0000_FFC0);
  endtask

  task automatic test_wid_mismatch();
    write_txn(16'd5, ADDR_A, 1'b0, 16'd6, ~data_a);
    read_txn(16'd4, ADDR_A);
  endtask

  task automatic test_tag_replace();
    logic [63:0] other;
    other = ADDR_A ^ 64'h0F00_0000_0001_0000;
    write_txn(16'd7, other, 1'b0, 16'd7, rand_line());
    read_txn(16'd8, ADDR_A);
    read_txn(16'd8, other);
  endtask

  task automatic test_back_to_back();
    logic [63:0] addrs [6];
    for (int i = 0; i < 6; i++) begin
      addrs[i] = {$urandom, $urandom};
      addrs[i][5:0] = 6'h0;
      if (i == 5) addrs[i][15:6] = addrs[1][15:6];
      write_txn(16'($urandom), addrs[i], 1'($urandom), 16'd0, rand_line());
    end
    for (int i = 0; i < 6; i++) begin
      write_txn(16'(i + 32), addrs[i], 1'(i), 16'(i + 32), rand_line());
    end
    for (int i = 5; i >= 0; i--) read_txn(16'(i + 100), addrs[i]);
  endtask

  // AR handshake two edges before AW so the W commit lands on the R sample edge.
  task automatic test_collision();
    logic [511:0] newd;
    write_txn(16'd2, ADDR_C, 1'b0, 16'd2, rand_line());
    newd = rand_line();
    push_write(16'd11, ADDR_C, 1'b1, 16'd11, newd);
    push_read(16'd12, ADDR_C);
    @(negedge clk);
    total++;
    if ({arready_o, awready_o} !== 2'b11)
      $display("FAIL coll_ready: arready/awready=%b want 11", {arready_o, awready_o});
    else passed++;
    arid_i = 16'd12; araddr_i = ADDR_C; arvalid_i = 1'b1;
    @(negedge clk);
    arvalid_i = 1'b0;
    @(negedge clk);
    awid_i = 16'd11; awaddr_i = ADDR_C; awuser_i = 1'b1; awvalid_i = 1'b1;
    @(negedge clk);
    awvalid_i = 1'b0;
    wid_i = 16'd11; wdata_i = newd; wvalid_i = 1'b1;
    @(negedge clk);
    wvalid_i = 1'b0;
    recv_r(-1);
    recv_b();
  endtask

  task automatic test_reset_mid_read();
    int n;
    push_read(16'd21, ADDR_A);
    send_ar(16'd21, ADDR_A);
    n = 0;
    while (rvalid_o !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    for (int c = 0; c < 4; c++) begin
      total++;
      if (rvalid_o !== 1'b1 || rdata_o !== {rq[0].tagw, rq[0].data} || rid_o !== rq[0].id)
        $display("FAIL hold_cycle%0d: rvalid=%b rid=%h tagword=%h want 1 %h %h",
                 c, rvalid_o, rid_o, rdata_o[575:512], rq[0].id, rq[0].tagw);
      else passed++;
      @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({rvalid_o, arready_o, awready_o} !== 3'b0)
      $display("FAIL async_reset_valid: rvalid/arready/awready=%b want 000",
               {rvalid_o, arready_o, awready_o});
    else passed++;
    total++;
    if ({rdata_o, rid_o, rhit_o} !== '0)
      $display("FAIL async_reset_rdata: rdata=%h rid=%h want 0", rdata_o, rid_o);
    else passed++;
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    total++;
    if ({rvalid_o, bvalid_o, arready_o} !== 3'b001)
      $display("FAIL post_reset_idle: rvalid/bvalid/arready=%b want 001",
               {rvalid_o, bvalid_o, arready_o});
    else passed++;
    read_txn(16'd22, ADDR_A);
    read_txn(16'd23, ADDR_C);
  endtask

  initial begin
    test_reset();
    test_write_read_hit();
    test_unwritten_read();
    test_wid_mismatch();
    test_tag_replace();
    test_back_to_back();
    test_collision();
    test_reset_mid_read();
    total++;
    if (rq.size() != 0 || bq.size() != 0)
      $display("FAIL scoreboard_drain: r left %0d b left %0d, want 0 0", rq.size(), bq.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
